mdu_ctrl: RTL and testbench

- Execute-stage multiply/divide sequencer for the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo (and optionally madd/msub family) from the E stage.
- Holds the operation for a fixed latency with `busy` asserted, then commits the result to the architectural HI/LO registers.
- The hazard unit uses `busy` to stall any following MD-class instruction or mfhi/mflo in D.

---
 rtl/mdu_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_ctrl
// Purpose  : Execute-stage multiply/divide sequencer. Accepts an MD-class
//            operation, computes the 64-bit result combinationally in the
//            accept cycle, holds busy for a fixed latency and then commits
//            the result to the architectural HI/LO registers.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-high reset, clears all state
//            start - E-stage instruction is MD-class (qualified by op)
//            op    - 0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,
//                    6 madd,7 maddu,8 msub,9 msubu (6..9 optional)
//            a, b  - rs / rt operands, sampled only in the accept cycle
//            busy  - registered, high while a mult/div is in flight
//            hi,lo - architectural HI / LO registers
// Options  : define MDU_MADD_EN to enable the madd/maddu/msub/msubu ops.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic             busy_n;
  logic [31:0]      hi_n, lo_n;
  logic [31:0]      ph, pl, ph_n, pl_n;   // pending result awaiting commit
  logic             pend_we, pend_we_n;   // cleared for divide by zero

  // --------------------------------------------------------------------------
  // Multiply: extend to 64 bits and keep the low 64 bits of the product,
  // which is exact for both signed and unsigned 32x32 operands.
  // --------------------------------------------------------------------------
  logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign a_zx   = {32'd0, a};
  assign b_zx   = {32'd0, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // --------------------------------------------------------------------------
  // Divide: signed division is done on magnitudes so that 0x80000000 / -1
  // wraps cleanly to 0x80000000 instead of overflowing. A zero divisor is
  // replaced by 1 to keep the datapath defined; its result is never written.
  // --------------------------------------------------------------------------
  logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign a_mag    = a[31] ? -a : a;
  assign b_mag    = b[31] ? -b : b;
  assign b_mag_nz = (b == 32'd0) ? 32'd1 : b_mag;
  assign b_nz     = (b == 32'd0) ? 32'd1 : b;
  assign q_mag    = a_mag / b_mag_nz;
  assign r_mag    = a_mag % b_mag_nz;
  assign q_s      = (a[31] ^ b[31]) ? -q_mag : q_mag;
  assign r_s      = a[31] ? -r_mag : r_mag;   // remainder follows dividend
  assign q_u      = a / b_nz;
  assign r_u      = a % b_nz;

`ifdef MDU_MADD_EN
  // Accumulate against HI/LO as they stand at the accept edge.
  logic [63:0] acc;
  assign acc = {hi, lo};
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      ph      <= 32'd0;
      pl      <= 32'd0;
      pend_we <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      busy    <= busy_n;
      hi      <= hi_n;
      lo      <= lo_n;
      ph      <= ph_n;
      pl      <= pl_n;
      pend_we <= pend_we_n;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    count_n   = count;
    busy_n    = busy;
    hi_n      = hi;
    lo_n      = lo;
    ph_n      = ph;
    pl_n      = pl;
    pend_we_n = pend_we;

    case (state)
      S_IDLE: begin
        // Any start seen while busy is in RUN and falls outside this branch.
        if (start) begin
          case (op)
            OP_MULT: begin
              {ph_n, pl_n} = prod_s;
              pend_we_n    = 1'b1;
              count_n      = MUL_CNT;
              busy_n       = 1'b1;
              state_n      = S_RUN;
            end
            OP_MULTU: begin
              {ph_n, pl_n} = prod_u;
              pend_we_n    = 1'b1;
              count_n      = MUL_CNT;
              busy_n       = 1'b1;
              state_n      = S_RUN;
            end
            OP_DIV: begin
              ph_n      = r_s;
              pl_n      = q_s;
              pend_we_n = (b != 32'd0);
              count_n   = DIV_CNT;
              busy_n    = 1'b1;
              state_n   = S_RUN;
            end
            OP_DIVU: begin
              ph_n      = r_u;
              pl_n      = q_u;
              pend_we_n = (b != 32'd0);
              count_n   = DIV_CNT;
              busy_n    = 1'b1;
              state_n   = S_RUN;
            end
            OP_MTHI: hi_n = a;
            OP_MTLO: lo_n = a;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {ph_n, pl_n} = acc + prod_s;
              pend_we_n    = 1'b1;
              count_n      = MUL_CNT;
              busy_n       = 1'b1;
              state_n      = S_RUN;
            end
            OP_MADDU: begin
              {ph_n, pl_n} = acc + prod_u;
              pend_we_n    = 1'b1;
              count_n      = MUL_CNT;
              busy_n       = 1'b1;
              state_n      = S_RUN;
            end
            OP_MSUB: begin
              {ph_n, pl_n} = acc - prod_s;
              pend_we_n    = 1'b1;
              count_n      = MUL_CNT;
              busy_n       = 1'b1;
              state_n      = S_RUN;
            end
            OP_MSUBU: begin
              {ph_n, pl_n} = acc - prod_u;
              pend_we_n    = 1'b1;
              count_n      = MUL_CNT;
              busy_n       = 1'b1;
              state_n      = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (count == '0) begin
          if (pend_we) begin
            hi_n = ph;
            lo_n = pl;
          end
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          count_n = count - CNT_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_ctrl
// Purpose  : Directed self-checking bench for mdu_ctrl (default latencies
//            MUL_LAT=5, DIV_LAT=10). Expected values are hand-computed.
//            Define MDU_MADD_EN for both bench and RTL to cover the
//            multiply-accumulate ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(
    .MUL_LAT(5),
    .DIV_LAT(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for a single accept cycle, then count how many cycles
  // busy stays high (bounded) and compare against the expected latency.
  task automatic run_op(input logic [3:0] o, input logic [31:0] oa,
                        input logic [31:0] ob, input int lat, input string tag);
    int n;
    start = 1'b1;
    op    = o;
    a     = oa;
    b     = ob;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'(lat));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 4'd0;
    a     = 32'd0;
    b     = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    // mult -2 * 3 = -6
    run_op(4'd0, 32'hFFFFFFFE, 32'd3, 5, "mult_lat");
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    // multu 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, "multu_lat");
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    // div -7 / 2 -> q=-3, r=-1
    run_op(4'd2, 32'hFFFFFFF9, 32'd2, 10, "div_lat");
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // divu 7 / 2 -> q=3, r=1
    run_op(4'd3, 32'd7, 32'd2, 10, "divu_lat");
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // Signed overflow corner
    run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, 10, "divovf_lat");
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h00000000);

    // mthi then mtlo back-to-back
    start = 1'b1;
    op    = 4'd4;
    a     = 32'h12345678;
    tick();
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", 32'(busy), 32'd0);
    op = 4'd5;
    a  = 32'h9ABCDEF0;
    tick();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_busy", 32'(busy), 32'd0);

    // divu by zero: full latency, HI/LO preserved
    run_op(4'd3, 32'd55, 32'd0, 10, "divz_lat");
    chk("divz_hi", hi, 32'h12345678);
    chk("divz_lo", lo, 32'h9ABCDEF0);

    // mult in flight; starts during busy must be ignored
    start = 1'b1;
    op    = 4'd0;
    a     = 32'h10;
    b     = 32'h20;
    tick();
    op = 4'd5;
    a  = 32'h0000DEAD;
    b  = 32'd7;
    tick();
    chk("ign_mtlo_busy", 32'(busy), 32'd1);
    chk("ign_mtlo_lo", lo, 32'h9ABCDEF0);
    op = 4'd0;
    a  = 32'hFFFF;
    b  = 32'hFFFF;
    tick();
    start = 1'b0;
    chk("ign_mult_lo", lo, 32'h9ABCDEF0);
    begin
      int n;
      n = 0;
      while (busy === 1'b1 && n < 64) begin
        n++;
        tick();
      end
      chk("ign_rem_lat", 32'(n), 32'd3);
    end
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'h200);

    // Async reset in RUN cycle 4 of a div
    start = 1'b1;
    op    = 4'd2;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) tick();
    chk("abort_nc_busy", 32'(busy), 32'd0);
    chk("abort_nc_hi", hi, 32'h0);
    chk("abort_nc_lo", lo, 32'h0);
    run_op(4'd0, 32'd5, 32'd7, 5, "post_lat");
    chk("post_hi", hi, 32'h0);
    chk("post_lo", lo, 32'd35);

    // Multiply-accumulate family: setup hi=0, lo=0xFFFFFFFF
    start = 1'b1;
    op    = 4'd5;
    a     = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    chk("macc_setup_lo", lo, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op(4'd7, 32'd1, 32'd1, 5, "maddu_lat");
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
    run_op(4'd8, 32'd1, 32'd1, 5, "msub_lat");
    chk("msub_hi", hi, 32'd0);
    chk("msub_lo", lo, 32'hFFFFFFFF);
`else
    start = 1'b1;
    op    = 4'd7;
    a     = 32'd1;
    b     = 32'd1;
    tick();
    start = 1'b0;
    chk("maddu_off_busy", 32'(busy), 32'd0);
    repeat (6) tick();
    chk("maddu_off_busy2", 32'(busy), 32'd0);
    chk("maddu_off_hi", hi, 32'd0);
    chk("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
